imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder on the fetch side of the core.
- Accepts fetch requests carrying the current PC from the fetch unit and returns the 32-bit instruction word after a programmable number of wait states.
- Cancels in-flight fetches when the fetch unit redirects to a branch target.
- Contains the instruction RAM, plus a word-wide loader write port used by the program loader.

Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 32-bit words; 12 gives 16 KiB.
- WAIT_CYCLES, 1, wait states between request acceptance and the response cycle; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.
- NOP_INST, 32'h0000_0013, instruction returned on error (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  fetch byte address (the PC).
- req_ready  out  1  responder can accept a request this cycle.
- flush  in  1  redirect (branch/jump taken); cancels any in-flight fetch.
- resp_valid  out  1  single-cycle pulse; resp_inst and resp_err are valid.
- resp_inst  out  32  fetched instruction word.
- resp_err  out  1  misaligned or out-of-range fetch.
- ld_we  in  1  loader write enable.
- ld_addr  in  DEPTH_LOG2  loader word index.
- ld_data  in  32  loader write data.

Behaviour:
- Reset: asynchronous, active-low.
  - State = IDLE, counter = 0, resp_valid = 0, resp_inst = NOP_INST, resp_err = 0, req_ready = 1.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = 1 in IDLE and RESP, 0 in WAIT.
- Acceptance: a request is accepted on an edge where req_valid && req_ready.
  - req_addr is latched and the error check is computed.
  - If WAIT_CYCLES == 0, go to RESP; otherwise go to WAIT with counter = WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; at counter == 0 go to RESP.
- Latency: a request accepted at edge T gives resp_valid high in the cycle following edge T+WAIT_CYCLES. Back-to-back requests with WAIT_CYCLES=0 give one response per cycle.
- RESP: resp_valid = 1 for exactly one cycle.
  - If a new request is accepted in this cycle, the next state is WAIT or RESP as above.
  - Otherwise the next state is IDLE.
- Memory data: the RAM is read synchronously on the edge that enters RESP, so resp_inst is registered.
- Error check (resp_err = 1, resp_inst = NOP_INST) when either holds:
  - req_addr[1:0] != 0;
  - req_addr < BASE_ADDR or req_addr >= BASE_ADDR + 4*2^DEPTH_LOG2.
  - Error requests still consume the full latency.
- Word index = (req_addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits. There is no wrap within range, because out-of-range addresses are flagged as errors.
- Flush:
  - In WAIT: abort; go to IDLE, and no response is ever produced for that request.
  - In RESP: resp_valid is forced to 0 combinationally (resp_valid = resp_q && !flush).
  - flush and req_valid in the same cycle: the old fetch is cancelled and the new request (the redirect target) is accepted normally.
- Loader:
  - ld_we writes ld_data to RAM[ld_addr] on the edge, in any state.
  - A read and write of the same word on the same edge returns the old data.
- resp_inst and resp_err hold their last values while resp_valid = 0.

Optional Feature:
- Macro: IMEM_PERF_CNT_EN.
- When defined, the block adds three output ports, each 32 bits, saturating, and zeroed on reset:
  - perf_fetch: counts responses actually delivered (resp_valid high).
  - perf_flush: counts fetches aborted in WAIT, plus responses suppressed in RESP.
  - perf_err: counts delivered responses with resp_err high.
- When undefined: these ports and their counters are absent, and all other behaviour is identical.

Decomposition:
- Shared definitions header holds:
  - FSM state encodings: IMEM_IDLE=2'd0, IMEM_WAIT=2'd1, IMEM_RESP=2'd2.
  - The NOP_INST constant.
  - The IMEM_PERF_CNT_EN switch.
- One sub-module: imem_ram, a single-port synchronous-read RAM with a separate write port, sized by DEPTH_LOG2. Keeping it separate allows a technology RAM to be swapped in.
- FSM, counter and error logic live in the top module.

Test Plan:
- WAIT_CYCLES=1, RAM[0]=32'h0010_0093, request addr 0 at edge T -> req_ready 0 in the next cycle; resp_valid pulses once after edge T+1 with inst 32'h0010_0093, err 0.
- WAIT_CYCLES=0, back-to-back requests 0x0, 0x4, 0x8 on consecutive edges -> three consecutive resp_valid pulses, returning RAM[0], RAM[1], RAM[2] in order.
- Request 0x2, then a request to 0x4000 with DEPTH_LOG2=12 -> both responses have err 1 and inst 32'h0000_0013.
- WAIT_CYCLES=3, flush one cycle after acceptance -> no resp_valid for that request; return to IDLE, req_ready 1.
- flush together with req_valid at addr 0x10 while in WAIT for addr 0x0 -> only the 0x10 response appears, with RAM[4].
- Reset asserted mid-WAIT -> resp_valid 0 immediately and asynchronously; after release, IDLE with req_ready 1. With IMEM_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encodings and constants.
// Define IMEM_PERF_CNT_EN at build time to add the perf_fetch/perf_flush/perf_err counters.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_t;

  localparam logic [31:0] IMEM_NOP_INST = 32'h0000_0013;
  localparam int unsigned IMEM_CNT_W    = 4;

  function automatic logic [31:0] imem_sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: synchronous read with enable, independent word-wide write port.
// Same-word read and write on one edge returns the old word.
module imem_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [31:0]           o_rd_data,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [31:0]           i_wr_data
);

  logic [31:0] r_mem [2**DEPTH_LOG2];
  logic [31:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction-memory responder with programmable wait states and flush.
// Optional build switch IMEM_PERF_CNT_EN adds saturating performance counters.
//   state     | meaning
//   IMEM_IDLE | no fetch outstanding, ready for a request
//   IMEM_WAIT | counting wait states for the accepted fetch
//   IMEM_RESP | response cycle, can accept the next request
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = IMEM_NOP_INST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [31:0]           resp_inst,
  output logic                  resp_err,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch,
  output logic [31:0]           perf_flush,
  output logic [31:0]           perf_err
`endif
);

  localparam logic [IMEM_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : IMEM_CNT_W'(WAIT_CYCLES - 1);
  localparam imem_state_t ACC_STATE = (WAIT_CYCLES == 0) ? IMEM_RESP : IMEM_WAIT;
  localparam logic [32:0] SPAN = 33'(4) << DEPTH_LOG2;

  imem_state_t            r_state;
  imem_state_t            w_next;
  logic [IMEM_CNT_W-1:0]  r_cnt;
  logic [31:0]            r_addr;
  logic                   r_err;
  logic                   r_use_nop;
  logic                   w_accept;
  logic                   w_enter_resp;
  logic                   w_err;
  logic [31:0]            w_src_addr;
  logic [31:0]            w_off;
  logic [DEPTH_LOG2-1:0]  w_idx;
  logic [31:0]            w_ram_q;

  assign req_ready = (r_state != IMEM_WAIT);
  // A redirect may replace the fetch being waited on, so flush also opens acceptance in WAIT.
  assign w_accept  = req_valid && (req_ready || flush);

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      w_next = ACC_STATE;
    end else begin
      case (r_state)
        IMEM_IDLE: w_next = IMEM_IDLE;
        IMEM_WAIT: begin
          if (flush) begin
            w_next = IMEM_IDLE;
          end else if (r_cnt == '0) begin
            w_next = IMEM_RESP;
          end
        end
        IMEM_RESP: w_next = IMEM_IDLE;
        default:   w_next = IMEM_IDLE;
      endcase
    end
  end

  assign w_enter_resp = (w_next == IMEM_RESP);
  assign w_src_addr   = w_accept ? req_addr : r_addr;
  assign w_off        = w_src_addr - BASE_ADDR;
  assign w_err        = (w_src_addr[1:0] != 2'b00) || (w_src_addr < BASE_ADDR) ||
                        ({1'b0, w_off} >= SPAN);
  assign w_idx        = w_off[DEPTH_LOG2+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IMEM_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_err     <= 1'b0;
      r_use_nop <= 1'b1;
    end else begin
      if (w_accept) begin
        r_cnt  <= WAIT_LOAD;
        r_addr <= req_addr;
      end else if ((r_state == IMEM_WAIT) && flush) begin
        r_cnt <= '0;
      end else if ((r_state == IMEM_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_enter_resp) begin
        r_err     <= w_err;
        r_use_nop <= w_err;
      end
    end
  end

  imem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk      (clk),
    .i_rd_en  (w_enter_resp && !w_err),
    .i_rd_addr(w_idx),
    .o_rd_data(w_ram_q),
    .i_we     (ld_we),
    .i_wr_addr(ld_addr),
    .i_wr_data(ld_data)
  );

  assign resp_valid = (r_state == IMEM_RESP) && !flush;
  assign resp_inst  = r_use_nop ? NOP_INST : w_ram_q;
  assign resp_err   = r_err;

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
      r_perf_err   <= '0;
    end else begin
      if (resp_valid) begin
        r_perf_fetch <= imem_sat_inc(r_perf_fetch);
      end
      if (resp_valid && r_err) begin
        r_perf_err <= imem_sat_inc(r_perf_err);
      end
      // Aborts in WAIT and suppressed responses in RESP both count as flushed fetches.
      if (flush && (r_state != IMEM_IDLE)) begin
        r_perf_flush <= imem_sat_inc(r_perf_flush);
      end
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_flush = r_perf_flush;
  assign perf_err   = r_perf_err;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances (0, 1 and 3 wait states) driven in turn
// from directed and random stimulus against a transaction-level reference model.
`timescale 1ns/1ps
module tb_imem_responder;

  localparam int          NI    = 3;
  localparam int          DL2   = 12;
  localparam int          DEPTH = 1 << DL2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    int          t;
    int          due;
    logic [DL2-1:0] idx;
    logic        err;
    logic [31:0] inst;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid [NI];
  logic [31:0]    req_addr  [NI];
  logic           req_ready [NI];
  logic           flush     [NI];
  logic           resp_valid[NI];
  logic [31:0]    resp_inst [NI];
  logic           resp_err  [NI];
  logic           ld_we     [NI];
  logic [DL2-1:0] ld_addr   [NI];
  logic [31:0]    ld_data   [NI];
`ifdef IMEM_PERF_CNT_EN
  logic [31:0]    perf_fetch[NI];
  logic [31:0]    perf_flush[NI];
  logic [31:0]    perf_err  [NI];
`endif

  exp_t        sb    [NI][$];
  logic [31:0] mem_m [NI][DEPTH];
  bit          alive [NI];
  int          last_t[NI];
  int          m_fetch[NI];
  int          m_flush[NI];
  int          m_err  [NI];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    imem_responder #(
      .DEPTH_LOG2 (DL2),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3)),
      .BASE_ADDR  (g == 2 ? 32'h0002_0000 : 32'h0000_0000),
      .NOP_INST   (NOP)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_addr  (req_addr[g]),
      .req_ready (req_ready[g]),
      .flush     (flush[g]),
      .resp_valid(resp_valid[g]),
      .resp_inst (resp_inst[g]),
      .resp_err  (resp_err[g]),
      .ld_we     (ld_we[g]),
      .ld_addr   (ld_addr[g]),
      .ld_data   (ld_data[g])
`ifdef IMEM_PERF_CNT_EN
      ,
      .perf_fetch(perf_fetch[g]),
      .perf_flush(perf_flush[g]),
      .perf_err  (perf_err[g])
`endif
    );
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, d, cyc, act, expv);
  endtask

  function automatic int wcyc(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h0002_0000 : 32'h0000_0000;
  endfunction

  function automatic bit is_err(input int d, input logic [31:0] a);
    longint x = longint'(a);
    longint b = longint'(base_of(d));
    return (a[1:0] != 2'b00) || (x < b) || (x >= b + 4 * DEPTH);
  endfunction

  // Scoreboard: a response is expected exactly in the cycle it is due.
  for (genvar g = 0; g < NI; g++) begin : g_mon
    always @(negedge clk) begin : mon
      exp_t x;
      bit   exp_v;
      exp_v = (sb[g].size() > 0) && (sb[g][0].due <= cyc);
      chk("resp_valid", g, 32'(resp_valid[g]), 32'(exp_v));
      if (exp_v) begin
        x = sb[g].pop_front();
        m_fetch[g]++;
        if (x.err) m_err[g]++;
        if (resp_valid[g] === 1'b1) begin
          chk("resp_inst", g, resp_inst[g], x.inst);
          chk("resp_err", g, 32'(resp_err[g]), 32'(x.err));
        end
      end
    end
  end

  // One clock of stimulus for instance d; inputs apply to the current cycle and the next edge.
  task automatic step(input int d, input bit rv, input logic [31:0] a, input bit fl,
                      input bit we, input logic [DL2-1:0] la, input logic [31:0] wd);
    int   e = cyc + 1;
    int   w = wcyc(d);
    bit   waiting;
    exp_t x;
    waiting = alive[d] && (last_t[d] < e) && (e <= last_t[d] + w);
    chk("req_ready", d, 32'(req_ready[d]), 32'(!waiting));
    if (fl) begin
      for (int i = sb[d].size() - 1; i >= 0; i--) begin
        if (sb[d][i].due == cyc || (waiting && sb[d][i].t == last_t[d])) begin
          sb[d].delete(i);
          m_flush[d]++;
        end
      end
      if (waiting) alive[d] = 1'b0;
    end
    if (rv && (!waiting || fl)) begin
      x.t    = e;
      x.due  = e + w;
      x.err  = is_err(d, a);
      x.idx  = DL2'((a - base_of(d)) >> 2);
      x.inst = '0;
      sb[d].push_back(x);
      alive[d]  = 1'b1;
      last_t[d] = e;
    end
    for (int i = 0; i < sb[d].size(); i++) begin
      if (sb[d][i].due == e) begin
        x = sb[d][i];
        x.inst = x.err ? NOP : mem_m[d][x.idx];
        sb[d][i] = x;
      end
    end
    if (we) mem_m[d][la] = wd;
    req_valid[d] = rv;
    req_addr[d]  = a;
    flush[d]     = fl;
    ld_we[d]     = we;
    ld_addr[d]   = la;
    ld_data[d]   = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
  endtask

  task automatic clear_model();
    for (int d = 0; d < NI; d++) begin
      sb[d].delete();
      alive[d]   = 1'b0;
      m_fetch[d] = 0;
      m_flush[d] = 0;
      m_err[d]   = 0;
    end
  endtask

  task automatic check_reset_state(input int d);
    chk("rst req_ready", d, 32'(req_ready[d]), 32'd1);
    chk("rst resp_valid", d, 32'(resp_valid[d]), 32'd0);
    chk("rst resp_inst", d, resp_inst[d], NOP);
    chk("rst resp_err", d, 32'(resp_err[d]), 32'd0);
`ifdef IMEM_PERF_CNT_EN
    chk("rst perf_fetch", d, perf_fetch[d], 32'd0);
    chk("rst perf_flush", d, perf_flush[d], 32'd0);
    chk("rst perf_err", d, perf_err[d], 32'd0);
`endif
  endtask

  // Assert reset between edges; outputs must react without a clock edge.
  task automatic reset_mid(input int d);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_reset_state(d);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DL2-1:0] pick_idx();
    int r = $urandom_range(0, 16);
    return (r == 16) ? DL2'(DEPTH - 1) : DL2'(r);
  endfunction

  function automatic logic [31:0] pick_addr(input int d);
    logic [31:0] b = base_of(d);
    logic [31:0] w = {18'b0, pick_idx(), 2'b00};
    int r = $urandom_range(0, 9);
    if (r == 0) return b + w + 32'($urandom_range(1, 3));
    if (r == 1) return b + 32'(4 * DEPTH);
    if (r == 2) return (b == 32'h0) ? 32'hFFFF_FFFC : b - 32'd4;
    return b + w;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] b2;
    b2 = 32'h0002_0000;
    rst_n = 1'b0;
    for (int d = 0; d < NI; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; flush[d] = 1'b0;
      ld_we[d] = 1'b0; ld_addr[d] = '0; ld_data[d] = '0;
    end
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NI; d++) check_reset_state(d);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < 16; i++) step(d, 1'b0, 32'h0, 1'b0, 1'b1, DL2'(i), $urandom);
      step(d, 1'b0, 32'h0, 1'b0, 1'b1, DL2'(DEPTH - 1), $urandom);
    end

    // One wait state: single fetch, then reset during its response cycle.
    step(1, 1'b0, 32'h0, 1'b0, 1'b1, DL2'(0), 32'h0010_0093);
    step(1, 1'b1, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    idle(1, 3);
    step(1, 1'b1, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    idle(1, 1);
    reset_mid(1);
    idle(1, 2);

    // Zero wait states: back-to-back, errors, and same-edge read/write of one word.
    step(0, 1'b1, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    step(0, 1'b1, 32'h4, 1'b0, 1'b0, '0, 32'h0);
    step(0, 1'b1, 32'h8, 1'b0, 1'b0, '0, 32'h0);
    step(0, 1'b1, 32'h2, 1'b0, 1'b0, '0, 32'h0);
    step(0, 1'b1, 32'h4000, 1'b0, 1'b0, '0, 32'h0);
    step(0, 1'b1, 32'h3FFC, 1'b0, 1'b0, '0, 32'h0);
    step(0, 1'b1, 32'h0, 1'b0, 1'b1, DL2'(0), 32'hCAFE_0001);
    step(0, 1'b1, 32'h0, 1'b1, 1'b0, '0, 32'h0);
    idle(0, 3);

    // Three wait states: abort, redirect while waiting, reset while waiting.
    step(2, 1'b0, 32'h0, 1'b0, 1'b1, DL2'(4), 32'h1234_5678);
    step(2, 1'b1, b2, 1'b0, 1'b0, '0, 32'h0);
    step(2, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0);
    idle(2, 5);
    step(2, 1'b1, b2, 1'b0, 1'b0, '0, 32'h0);
    idle(2, 1);
    step(2, 1'b1, b2 + 32'h10, 1'b1, 1'b0, '0, 32'h0);
    idle(2, 6);
    step(2, 1'b1, b2 + 32'h8, 1'b0, 1'b0, '0, 32'h0);
    idle(2, 1);
    reset_mid(2);
    idle(2, 2);

    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < 400; i++) begin
        step(d, ($urandom_range(0, 2) != 0), pick_addr(d), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) == 0), pick_idx(), $urandom);
      end
      idle(d, 8);
      chk("drained", d, 32'(sb[d].size()), 32'd0);
`ifdef IMEM_PERF_CNT_EN
      chk("perf_fetch", d, perf_fetch[d], 32'(m_fetch[d]));
      chk("perf_flush", d, perf_flush[d], 32'(m_flush[d]));
      chk("perf_err", d, perf_err[d], 32'(m_err[d]));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
